fifo_rd_serializer: RTL and testbench
=====================================

# fifo_rd_serializer

Read-side consumer for the asynchronous FIFO, clocked in the FIFO's read domain. It pulls 64-bit words through the FIFO's registered-read port and absorbs the one-cycle read latency in a 3-entry prefetch buffer. Each word is split into narrower beats, least-significant slice first, and presented on a valid/ready stream to downstream logic. It sustains one beat per cycle while the FIFO is non-empty.

## Interface
- FIFO_WIDTH, 64: FIFO word width; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 16: output beat width; RATIO = FIFO_WIDTH/OUT_WIDTH (1..8).
- clk  input  1  read-domain clock (same net as the FIFO's rdclk).
- rst  input  1  synchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag (registered in the FIFO).
- fifo_data  input  FIFO_WIDTH  FIFO data_out; valid the cycle after a read is issued.
- fifo_rd_en  output  1  read request to the FIFO.
- m_valid  output  1  output beat valid.
- m_ready  input  1  downstream accepts beat.
- m_data  output  OUT_WIDTH  output beat.
- m_last  output  1  beat is the final slice of its word.
- word_cnt  output  16  count of fully emitted words; wraps modulo 2^16.

## Operation
- Credit rule: fifo_rd_en = !fifo_empty && (occ + inflight) < 3.
  - occ is the number of buffered words (0..3).
  - inflight is a register set when fifo_rd_en is asserted, cleared otherwise.
  - fifo_rd_en is never asserted while fifo_empty=1.
  - fifo_rd_en does not depend on m_ready, so there is no combinational path from m_ready to fifo_rd_en.
- Capture: when inflight=1, fifo_data is written to the buffer tail at the end of that cycle.
- Buffer: 3-entry circular store with 2-bit head and tail pointers, each wrapping 2→0.
  - A push and a pop in the same cycle leave occ unchanged.
  - Overflow cannot occur under the credit rule; a bench assertion checks it.
- Serializer: a beat counter `beat` (0..RATIO-1) selects the slice of the head word.
  - m_data = head[beat*OUT_WIDTH +: OUT_WIDTH].
  - m_valid = (occ != 0).
  - m_last = (beat == RATIO-1).
- Handshake, beat accepted when m_valid && m_ready:
  - If m_last=0: beat increments.
  - If m_last=1: beat returns to 0, the head word is popped, and word_cnt increments.
- With RATIO=1, every beat has m_last=1.
- Once m_valid is asserted, m_data and m_last are held stable until the beat is accepted.
- Reset: clears occ, pointers, beat, inflight and word_cnt.
  - Outputs after reset: fifo_rd_en=0, m_valid=0, m_last=0 when RATIO>1, m_data=0, word_cnt=0.
  - Buffer storage is not reset; m_data is masked to 0 while occ=0.
- Reset mid-operation:
  - A word in flight, and any buffered words, are discarded.
  - The FIFO read pointer has already advanced, so those words are lost by design.
  - Upstream must reset both domains together if loss is unacceptable.

## Timing
- Read issue: fifo_rd_en high in cycle N → data captured at end of N+1 → m_valid high in N+2.
- Minimum latency from fifo_empty deasserting to m_valid is 2 cycles, excluding the FIFO's own synchronizer latency.
- Throughput: 3 buffer entries cover the 2-cycle round trip.
  - With RATIO=1 and m_ready held high, one word per cycle is sustained.
  - With RATIO>1, one beat per cycle is sustained.
- Backpressure: with m_ready=0, reads stop once occ+inflight=3; at most 3 words are held.
- fifo_empty rising while inflight=1: the pending capture still completes; no further reads are issued.

## Structure
- A shared package `fifo_rd_pkg` holds:
  - localparam RATIO and beat-index width, computed from the parameters;
  - BUF_DEPTH=3;
  - the elaboration check that FIFO_WIDTH % OUT_WIDTH == 0.
- Sub-module `rd_word_buf` is the 3-entry buffer with push/pop, occ, and head-word output.
- The top level contains the credit logic, the inflight register, the serializer, and word_cnt.

## Test plan
- Reset, then FIFO loaded with words 0x1111_2222_3333_4444 and 0x5555_6666_7777_8888, m_ready=1 → beats 0x4444, 0x3333, 0x2222, 0x1111 (last), 0x8888, …, 0x5555 (last); word_cnt=2.
- RATIO=1, 10 words preloaded, m_ready=1 → 10 consecutive cycles of m_valid with no bubble after the first; first m_valid 2 cycles after the first fifo_rd_en.
- m_ready=0 with 8 words available → fifo_rd_en pulses exactly 3 times, occ=3, m_data stable. Release m_ready → all 8 words emitted in order.
- Assert rst with occ=2 and inflight=1 → next cycle m_valid=0, word_cnt=0, fifo_rd_en=0. Resume → the next FIFO word is the first emitted.
- fifo_empty toggling every cycle with random m_ready → output sequence equals the write sequence; no fifo_rd_en while fifo_empty=1; occ never exceeds 3.
- 65 537 words streamed → word_cnt wraps to 1.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared constants and helpers for the FIFO read-side serializer.
// Holds the default widths, the beat ratio and beat-index width, the buffer depth,
// and the width-compatibility check used at elaboration.
package fifo_rd_pkg;

   localparam int FIFO_WIDTH_DEF = 64;
   localparam int OUT_WIDTH_DEF  = 16;
   localparam int BUF_DEPTH      = 3;
   localparam int PTR_W          = 2;
   localparam int WORD_CNT_W     = 16;

   function automatic int ratio_of(input int fw, input int ow);
      return fw / ow;
   endfunction

   // A single-beat word still needs a 1-bit beat index.
   function automatic int beat_w_of(input int ratio);
      return (ratio > 1) ? $clog2(ratio) : 1;
   endfunction

   // The word must split into a whole number of beats, 1 to 8 of them.
   function automatic bit width_ok(input int fw, input int ow);
      return (ow > 0) && ((fw % ow) == 0) && ((fw / ow) >= 1) && ((fw / ow) <= 8);
   endfunction

   localparam int RATIO  = ratio_of(FIFO_WIDTH_DEF, OUT_WIDTH_DEF);
   localparam int BEAT_W = beat_w_of(RATIO);

   // Pointer advance with wrap from the last entry back to 0.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

endpackage

// File: rtl/rd_word_buf.sv
// 3-entry circular word buffer: push at tail, pop at head, occupancy count.
// Latency: a pushed word is visible on head_dat the cycle after the push.
// Backpressure: none internally; the caller guarantees no push when full, no pop when empty.
// Ports: clk/rst (sync, active-high); push/push_dat write; pop retires the head;
//        occ = buffered word count; head_dat = oldest word (undefined while occ=0).
module rd_word_buf
   import fifo_rd_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [PTR_W-1:0] occ,
   output logic [WIDTH-1:0] head_dat
);

   logic [WIDTH-1:0] mem_q [BUF_DEPTH];
   logic [WIDTH-1:0] mem_d [BUF_DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [PTR_W-1:0] occ_q,  occ_d;

   always_comb begin
      mem_d  = mem_q;
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      if (push) begin
         mem_d[tail_q] = push_dat;
         tail_d        = ptr_inc(tail_q);
      end
      if (pop) begin
         head_d = ptr_inc(head_q);
      end
      // Simultaneous push and pop leave the count unchanged.
      case ({push, pop})
         2'b10:   occ_d = occ_q + PTR_W'(1);
         2'b01:   occ_d = occ_q - PTR_W'(1);
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

   // Storage is data-only and deliberately not reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign occ      = occ_q;
   assign head_dat = mem_q[head_q];

endmodule

// File: rtl/fifo_rd_serializer.sv
// Pulls FIFO words through a registered-read port and emits them LS slice first as beats.
// Latency: fifo_rd_en in cycle N gives m_valid in N+2; one beat per cycle sustained.
// Backpressure: m_ready low stalls beats; reads stop once buffered + in-flight words reach 3.
// Ports: clk/rst (sync, active-high); fifo_empty/fifo_data/fifo_rd_en to the FIFO read side;
//        m_valid/m_ready/m_data/m_last beat stream; word_cnt = words fully emitted (mod 2^16).
module fifo_rd_serializer
   import fifo_rd_pkg::*;
#(
   parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
   parameter int OUT_WIDTH  = OUT_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   input  logic [FIFO_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd_en,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [OUT_WIDTH-1:0]  m_data,
   output logic                  m_last,
   output logic [WORD_CNT_W-1:0] word_cnt
);

   localparam int N_BEATS = ratio_of(FIFO_WIDTH, OUT_WIDTH);
   localparam int BW      = beat_w_of(N_BEATS);

   if (!width_ok(FIFO_WIDTH, OUT_WIDTH)) begin : g_bad_width
      $error("fifo_rd_serializer: FIFO_WIDTH must be 1..8 times OUT_WIDTH");
   end

   logic                  inflight_q, inflight_d;
   logic [BW-1:0]         beat_q,     beat_d;
   logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
   logic [PTR_W-1:0]      occ;
   logic [FIFO_WIDTH-1:0] head_dat;
   logic [OUT_WIDTH-1:0]  slice;
   logic                  accept;
   logic                  pop;

   // Credit: buffered plus in-flight words may never exceed the buffer depth.
   // Independent of m_ready so there is no ready-to-read combinational path.
   // Gated by rst so no word is pulled from the FIFO while the buffer is being cleared.
   assign fifo_rd_en = !rst && !fifo_empty &&
                       ((3'(occ) + 3'(inflight_q)) < 3'(BUF_DEPTH));

   rd_word_buf #(
      .WIDTH (FIFO_WIDTH)
   ) u_buf (
      .clk      (clk),
      .rst      (rst),
      .push     (inflight_q),
      .push_dat (fifo_data),
      .pop      (pop),
      .occ      (occ),
      .head_dat (head_dat)
   );

   always_comb begin
      slice = '0;
      for (int i = 0; i < N_BEATS; i++) begin
         if (beat_q == BW'(i)) slice = head_dat[i*OUT_WIDTH +: OUT_WIDTH];
      end
   end

   assign m_valid = (occ != '0);
   assign m_last  = (beat_q == BW'(N_BEATS - 1));
   // Storage is not reset, so mask the slice while nothing is buffered.
   assign m_data  = m_valid ? slice : '0;
   assign accept  = m_valid && m_ready;
   assign pop     = accept && m_last;

   always_comb begin
      inflight_d = fifo_rd_en;
      beat_d     = beat_q;
      word_cnt_d = word_cnt_q;
      if (accept) begin
         beat_d = m_last ? '0 : beat_q + BW'(1);
      end
      if (pop) begin
         word_cnt_d = word_cnt_q + WORD_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_q <= 1'b0;
         beat_q     <= '0;
         word_cnt_q <= '0;
      end else begin
         inflight_q <= inflight_d;
         beat_q     <= beat_d;
         word_cnt_q <= word_cnt_d;
      end
   end

   assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_fifo_rd_serializer.sv
module tb_fifo_rd_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   // 64-bit word, 16-bit beat instance
   logic        fifo_empty;
   logic [63:0] fifo_data;
   logic        fifo_rd_en;
   logic        m_valid, m_ready, m_last;
   logic [15:0] m_data;
   logic [15:0] word_cnt;
   // single-beat instance (64-bit beat)
   logic        fifo_empty1;
   logic [63:0] fifo_data1;
   logic        fifo_rd_en1;
   logic        m_valid1, m_ready1, m_last1;
   logic [63:0] m_data1;
   logic [15:0] word_cnt1;

   fifo_rd_serializer #(.FIFO_WIDTH(64), .OUT_WIDTH(16)) u_dut (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
      .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .m_last(m_last), .word_cnt(word_cnt));

   fifo_rd_serializer #(.FIFO_WIDTH(64), .OUT_WIDTH(64)) u_dut1 (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty1), .fifo_data(fifo_data1),
      .fifo_rd_en(fifo_rd_en1), .m_valid(m_valid1), .m_ready(m_ready1),
      .m_data(m_data1), .m_last(m_last1), .word_cnt(word_cnt1));

   typedef struct packed {
      logic [15:0] d;
      logic        l;
   } beat_t;

   int errors = 0;
   int checks = 0;

   logic [63:0] fifo_q [$];
   beat_t       exp_q  [$];

   int   cyc = 0;
   int   held = 0, rd_pulses = 0, exp_words = 0;
   int   first_rd = -1, first_vld = -1, last_acc = -1;
   int   rdy_mode = 0;
   bit   toggle_mode = 0, gate_empty = 0;
   bit   stall_prev = 0;
   logic [15:0] stall_d;
   logic        stall_l;
   int   acc1 = 0, src1_next = 0, src1_avail = 0;
   int   first_rd1 = -1, first_vld1 = -1, last_acc1 = -1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] src1_word(input int idx);
      logic [31:0] v;
      v = 32'(idx);
      return {v, ~v};
   endfunction

   task automatic push_beats(input logic [63:0] w);
      for (int i = 0; i < 4; i++) exp_q.push_back('{d: w[i*16 +: 16], l: (i == 3)});
   endtask

   task automatic load(input logic [63:0] w);
      fifo_q.push_back(w);
      push_beats(w);
      fifo_empty = gate_empty;
   endtask

   task automatic rebuild();
      exp_q.delete();
      foreach (fifo_q[k]) push_beats(fifo_q[k]);
   endtask

   // One clock: check outputs at negedge, then update the FIFO models after the edge.
   task automatic cycle();
      beat_t e;
      logic  rd_s, rd1_s;
      @(negedge clk);
      if (!rst) begin
         if (fifo_rd_en) begin
            chk("rd_while_empty", fifo_empty, 1'b0);
            held++;
            rd_pulses++;
            if (first_rd < 0) first_rd = cyc;
         end
         if (stall_prev) begin
            chk("hold_valid", m_valid, 1'b1);
            chk("hold_data", m_data, stall_d);
            chk("hold_last", m_last, stall_l);
         end
         if (m_valid && first_vld < 0) first_vld = cyc;
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               chk("spurious_beat", m_valid, 1'b0);
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", m_data, e.d);
               chk("beat_last", m_last, e.l);
               if (e.l) begin
                  held--;
                  exp_words++;
               end
               last_acc = cyc;
            end
         end
         chk("held_le_3", held <= 3, 1'b1);
         stall_prev = m_valid && !m_ready;
         stall_d    = m_data;
         stall_l    = m_last;
         // single-beat instance
         if (fifo_rd_en1) begin
            chk("rd1_while_empty", fifo_empty1, 1'b0);
            if (first_rd1 < 0) first_rd1 = cyc;
         end
         if (m_valid1 && first_vld1 < 0) first_vld1 = cyc;
         if (m_valid1 && m_ready1) begin
            chk("r1_data", m_data1, src1_word(acc1));
            chk("r1_last", m_last1, 1'b1);
            acc1++;
            last_acc1 = cyc;
         end
      end else begin
         stall_prev = 0;
      end
      rd_s  = fifo_rd_en;
      rd1_s = fifo_rd_en1;
      @(posedge clk);
      #1;
      cyc++;
      if (rd_s === 1'b1 && fifo_q.size() != 0) fifo_data = fifo_q.pop_front();
      if (toggle_mode) gate_empty = !gate_empty;
      fifo_empty = (fifo_q.size() == 0) || gate_empty;
      case (rdy_mode)
         0:       m_ready = 1'b0;
         1:       m_ready = 1'b1;
         default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (rd1_s === 1'b1 && src1_avail > 0) begin
         fifo_data1 = src1_word(src1_next);
         src1_next++;
         src1_avail--;
      end
      fifo_empty1 = (src1_avail == 0);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         cycle();
         n++;
      end
      chk("drain_done", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rd_en"}, fifo_rd_en, 1'b0);
      chk({tag, "_valid"}, m_valid, 1'b0);
      chk({tag, "_last"}, m_last, 1'b0);
      chk({tag, "_data"}, m_data, 16'h0);
      chk({tag, "_wcnt"}, word_cnt, 16'h0);
   endtask

   initial begin
      rst = 1'b1;
      fifo_empty = 1'b1; fifo_data = '0; m_ready = 1'b0;
      fifo_empty1 = 1'b1; fifo_data1 = '0; m_ready1 = 1'b0;
      cycle();
      cycle();
      check_reset_outputs("reset");
      rst = 1'b0;

      // Two directed words, slices LS first.
      rdy_mode = 1; m_ready = 1'b1;
      first_rd = -1; first_vld = -1;
      load(64'h1111_2222_3333_4444);
      load(64'h5555_6666_7777_8888);
      drain(200);
      chk("first_latency", 64'(first_vld - first_rd), 64'd2);
      chk("word_cnt_2", word_cnt, 16'd2);

      // Ten random words: one beat per cycle, no bubble after the first.
      first_vld = -1;
      for (int i = 0; i < 10; i++) load({$urandom, $urandom});
      drain(400);
      chk("no_bubble", 64'(last_acc - first_vld), 64'd39);
      chk("word_cnt_12", word_cnt, 16'd12);

      // Backpressure: exactly three reads, then hold.
      rdy_mode = 0; m_ready = 1'b0; rd_pulses = 0;
      for (int i = 0; i < 8; i++) load({$urandom, $urandom});
      repeat (10) cycle();
      chk("bp_rd_pulses", 64'(rd_pulses), 64'd3);
      chk("bp_held", 64'(held), 64'd3);
      rdy_mode = 1; m_ready = 1'b1;
      drain(400);
      chk("word_cnt_20", word_cnt, 16'd20);

      // Reset with two words buffered and one in flight.
      rdy_mode = 0; m_ready = 1'b0;
      for (int i = 0; i < 8; i++) load({$urandom, $urandom});
      repeat (3) cycle();
      chk("pre_rst_held", 64'(held), 64'd3);
      rst = 1'b1;
      cycle();
      check_reset_outputs("midrst");
      rst = 1'b0;
      held = 0; exp_words = 0;
      rebuild();
      rdy_mode = 1; m_ready = 1'b1;
      drain(400);
      chk("word_cnt_after_rst", word_cnt, 16'd5);

      // Empty flag toggling every cycle with random ready.
      toggle_mode = 1; rdy_mode = 2;
      for (int i = 0; i < 20; i++) load({$urandom, $urandom});
      drain(3000);
      toggle_mode = 0; gate_empty = 1'b0; rdy_mode = 1;
      cycle();
      chk("word_cnt_25", word_cnt, 16'd25);

      // Single-beat instance: latency and one word per cycle.
      m_ready1 = 1'b1;
      src1_avail = 10; fifo_empty1 = 1'b0;
      begin
         int n = 0;
         while (acc1 < 10 && n < 100) begin cycle(); n++; end
      end
      chk("r1_count10", 64'(acc1), 64'd10);
      chk("r1_latency", 64'(first_vld1 - first_rd1), 64'd2);
      chk("r1_no_bubble", 64'(last_acc1 - first_vld1), 64'd9);
      chk("r1_word_cnt10", word_cnt1, 16'd10);

      // Word counter wrap after 65537 words.
      src1_avail = 65527; fifo_empty1 = 1'b0;
      begin
         int n = 0;
         while (acc1 < 65537 && n < 70000) begin cycle(); n++; end
      end
      chk("r1_count_wrap", 64'(acc1), 64'd65537);
      chk("word_cnt_wrap", word_cnt1, 16'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
